nibble_pair_reader: RTL and testbench

Read-side counterpart to the split-nibble writer scheme: two independent producers each drive one half of a byte (low nibble, high nibble) through their own valid/ready port. This block captures each half, merges each completed pair into a byte `{hi, lo}`, and buffers merged bytes in a small show-ahead FIFO. A downstream consumer drains that FIFO over a valid/ready handshake. It sits between the nibble producers and any byte-wide consumer, e.g. a top-level output register.

---
 rtl/nibble_pair_reader_if.sv | 29 ++
 rtl/nibble_pair_reader.sv | 100 ++++++++++
 tb/tb_nibble_pair_reader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_pair_reader_if.sv
// Handshake bundle between the two nibble producers, the reader and the byte consumer.
// The slave modport is the reader side; the master modport is the producer/consumer side.
interface nibble_pair_reader_if #(
  parameter int NIBBLE_W = 4,
  parameter int DEPTH    = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic                  i_lo_valid;
  logic [NIBBLE_W-1:0]   i_lo_data;
  logic                  o_lo_ready;
  logic                  i_hi_valid;
  logic [NIBBLE_W-1:0]   i_hi_data;
  logic                  o_hi_ready;
  logic                  o_valid;
  logic [2*NIBBLE_W-1:0] o_data;
  logic                  i_ready;
  logic [LW-1:0]         o_level;

  modport slave (
    input  i_lo_valid, i_lo_data, i_hi_valid, i_hi_data, i_ready,
    output o_lo_ready, o_hi_ready, o_valid, o_data, o_level
  );

  modport master (
    output i_lo_valid, i_lo_data, i_hi_valid, i_hi_data, i_ready,
    input  o_lo_ready, o_hi_ready, o_valid, o_data, o_level
  );
endinterface

// File: rtl/nibble_pair_reader.sv
// Captures independent low/high nibble halves, merges each completed pair into {hi, lo}
// and queues merged bytes in a show-ahead FIFO drained over valid/ready.
module nibble_pair_reader #(
  parameter int NIBBLE_W = 4,
  parameter int DEPTH    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  nibble_pair_reader_if.slave  bus
);
  localparam int W  = 2 * NIBBLE_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [NIBBLE_W-1:0] lo_q, lo_d;
  logic [NIBBLE_W-1:0] hi_q, hi_d;
  logic                lo_full_q, lo_full_d;
  logic                hi_full_q, hi_full_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [W-1:0]        mem_q [DEPTH];

  logic merge, lo_ready, hi_ready, lo_acc, hi_acc, pop, valid;

  // Merge looks at the registered level only, so a pop on a full FIFO frees space next cycle.
  assign merge    = lo_full_q & hi_full_q & (level_q < LW'(DEPTH));
  assign lo_ready = ~lo_full_q | merge;
  assign hi_ready = ~hi_full_q | merge;
  assign lo_acc   = bus.i_lo_valid & lo_ready;
  assign hi_acc   = bus.i_hi_valid & hi_ready;
  assign valid    = (level_q != '0);
  assign pop      = valid & bus.i_ready;

  always_comb begin
    lo_d      = lo_q;
    hi_d      = hi_q;
    lo_full_d = lo_full_q;
    hi_full_d = hi_full_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;

    if (merge) begin
      lo_full_d = 1'b0;
      hi_full_d = 1'b0;
      wr_ptr_d  = wr_ptr_q + AW'(1);
    end
    // A half accepted in the merge cycle reloads the register and keeps the flag set.
    if (lo_acc) begin
      lo_d      = bus.i_lo_data;
      lo_full_d = 1'b1;
    end
    if (hi_acc) begin
      hi_d      = bus.i_hi_data;
      hi_full_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(merge) - LW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lo_q      <= '0;
      hi_q      <= '0;
      lo_full_q <= 1'b0;
      hi_full_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      lo_full_q <= lo_full_d;
      hi_full_q <= hi_full_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        mem_q[gi] <= '0;
      end else if (merge && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= {hi_q, lo_q};
      end
    end
  end

  assign bus.o_lo_ready = lo_ready;
  assign bus.o_hi_ready = hi_ready;
  assign bus.o_valid    = valid;
  assign bus.o_data     = mem_q[rd_ptr_q];
  assign bus.o_level    = level_q;
endmodule

// File: tb/tb_nibble_pair_reader.sv
// Directed bench for nibble_pair_reader: expected bytes go into a scoreboard queue at
// issue time and a monitor compares them against every pop handshake.
module tb_nibble_pair_reader;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_pair_reader_if #(.NIBBLE_W(4), .DEPTH(4)) bus ();

  nibble_pair_reader #(.NIBBLE_W(4), .DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int asserts  = 0;
  int failures = 0;
  int stalls   = 0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: one line per popped byte.
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", {24'h0, bus.o_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("pop_data", {24'h0, bus.o_data}, {24'h0, e});
      end
    end
  end

  // Occupancy bound checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst && (bus.o_level > 3'd4)) begin
      check("level_bound", {29'h0, bus.o_level}, 32'd4);
    end
  end

  task automatic push_lo(input logic [3:0] d);
    int   n;
    logic acc;
    n = 0;
    bus.i_lo_valid = 1'b1;
    bus.i_lo_data  = d;
    do begin
      @(negedge clk);
      acc = bus.o_lo_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) check("lo_accept_timeout", 32'd0, 32'd1);
    if (n > 1) stalls++;
    bus.i_lo_valid = 1'b0;
  endtask

  task automatic push_hi(input logic [3:0] d);
    int   n;
    logic acc;
    n = 0;
    bus.i_hi_valid = 1'b1;
    bus.i_hi_data  = d;
    do begin
      @(negedge clk);
      acc = bus.o_hi_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) check("hi_accept_timeout", 32'd0, 32'd1);
    if (n > 1) stalls++;
    bus.i_hi_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [3:0] lo, input logic [3:0] hi);
    sb.push_back({hi, lo});
    fork
      push_lo(lo);
      push_hi(hi);
    join
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", sb.size(), 32'd0);
    @(posedge clk);
    #1;
    check("drain_valid", {31'h0, bus.o_valid}, 32'd0);
    check("drain_level", {29'h0, bus.o_level}, 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.i_lo_valid = 1'b0;
    bus.i_lo_data  = '0;
    bus.i_hi_valid = 1'b0;
    bus.i_hi_data  = '0;
    bus.i_ready    = 1'b0;
    rst = 1'b1;

    // Reset values
    tick(2);
    rst = 1'b0;
    check("rst_valid", {31'h0, bus.o_valid}, 32'd0);
    check("rst_data", {24'h0, bus.o_data}, 32'h00);
    check("rst_level", {29'h0, bus.o_level}, 32'd0);
    check("rst_lo_ready", {31'h0, bus.o_lo_ready}, 32'd1);
    check("rst_hi_ready", {31'h0, bus.o_hi_ready}, 32'd1);

    // Split-cycle pair: lo first, hi three cycles later
    sb.push_back(8'hF0);
    push_lo(4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("split_lo_stall", {31'h0, bus.o_lo_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    push_hi(4'hF);
    check("split_valid_e", {31'h0, bus.o_valid}, 32'd0);
    tick(1);
    check("split_valid_e1", {31'h0, bus.o_valid}, 32'd1);
    check("split_data", {24'h0, bus.o_data}, 32'hF0);
    check("split_level", {29'h0, bus.o_level}, 32'd1);
    drain();

    // Streaming at full rate
    stalls = 0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_pair(4'(i), 4'(15 - i));
    end
    check("stream_stalls", stalls, 32'd0);
    drain();

    // Full FIFO backpressure
    bus.i_ready = 1'b0;
    send_pair(4'h1, 4'h2);
    send_pair(4'h3, 4'h4);
    send_pair(4'h5, 4'h6);
    send_pair(4'h7, 4'h8);
    fork
      begin
        send_pair(4'h9, 4'hA);
        send_pair(4'hB, 4'hC);
      end
      begin
        tick(6);
        check("full_level", {29'h0, bus.o_level}, 32'd4);
        check("full_lo_ready", {31'h0, bus.o_lo_ready}, 32'd0);
        check("full_hi_ready", {31'h0, bus.o_hi_ready}, 32'd0);
        check("full_head", {24'h0, bus.o_data}, 32'h21);
        bus.i_ready = 1'b1;
        tick(1);
        bus.i_ready = 1'b0;
        check("full_after_pop", {29'h0, bus.o_level}, 32'd3);
        tick(1);
        check("full_refill", {29'h0, bus.o_level}, 32'd4);
        check("full_next_head", {24'h0, bus.o_data}, 32'h43);
        check("full_lo_ready2", {31'h0, bus.o_lo_ready}, 32'd0);
        tick(2);
        bus.i_ready = 1'b1;
      end
    join
    drain();

    // Wrap-around with random consumer
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 10; i++) begin
            send_pair(4'(i + 3), 4'(12 - i));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            bus.i_ready = 1'($urandom_range(0, 1));
            tick(1);
          end
        end
      join
    end
    drain();

    // Mid-operation reset with a held lo half
    bus.i_ready = 1'b0;
    send_pair(4'h1, 4'h1);
    send_pair(4'h2, 4'h2);
    send_pair(4'h3, 4'h3);
    push_lo(4'hD);
    tick(1);
    check("pre_rst_level", {29'h0, bus.o_level}, 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sb.delete();
    check("mid_rst_level", {29'h0, bus.o_level}, 32'd0);
    check("mid_rst_valid", {31'h0, bus.o_valid}, 32'd0);
    check("mid_rst_lo_ready", {31'h0, bus.o_lo_ready}, 32'd1);
    send_pair(4'h6, 4'h9);
    tick(1);
    check("post_rst_data", {24'h0, bus.o_data}, 32'h96);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
